// File: rtl/montgomery_reduce_if.sv
// rtl/montgomery_reduce_if.sv - start/done handshake bundle for the Montgomery reduction stage
//
// Signals:
//   start   request from the multiplier side, sampled only while the reducer is idle
//   t_in    2*WIDTH-bit product to reduce, captured when start is accepted
//   busy    reducer is working on a job
//   done    one-cycle pulse, result valid in the same cycle
//   result  reduced value in [0, P), held until the next accepted start
// Modports: master drives start/t_in, slave (the reducer) drives busy/done/result.
interface montgomery_reduce_if #(
  parameter int WIDTH = 377
);
  logic                 start;
  logic [2*WIDTH-1:0]   t_in;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     result;

  modport master (output start, output t_in, input busy, input done, input result);
  modport slave  (input start, input t_in, output busy, output done, output result);
endinterface

// File: rtl/montgomery_reduce.sv
// rtl/montgomery_reduce.sv - word-serial Montgomery reduction (REDC): result = t_in * R^-1 mod P
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    montgomery_reduce_if.slave: start/t_in in, busy/done/result out
// One reduction in flight. Latency from acceptance to done is N_WORDS+2 edges
// (acceptance edge, N_WORDS digit iterations, one final-subtract cycle).
module montgomery_reduce #(
  parameter int                WIDTH     = 377,
  parameter int                WORD      = 64,
  parameter int                N_WORDS   = (WIDTH + WORD - 1) / WORD,
  parameter logic [WIDTH-1:0]  P         = 377'h1ae3a46_17c510ea_c63b05c0_6ca1493b_1a22d9f3_00f5138f_1ef3622f_ba094800_170b5d44_30000000_8508c000_00000001,
  parameter logic [WORD-1:0]   P_INV_NEG = 64'h8508bfff_ffffffff
) (
  input  logic                 clk,
  input  logic                 reset,
  montgomery_reduce_if.slave   bus
);

  // Wide enough for t_in + m*P*2^(WORD*i) accumulated over all digits.
  localparam int ACC_W = N_WORDS * WORD + WIDTH + 2;
  localparam int CNT_W = $clog2(N_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  i;
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  result_q;

  logic [WORD-1:0]   m;
  logic [ACC_W-1:0]  sum;

  // m is chosen so the low digit of acc + m*P is zero, making the shift exact.
  always_comb begin
    m   = WORD'(acc[WORD-1:0] * P_INV_NEG);
    sum = acc + ACC_W'(m) * ACC_W'(P);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      acc      <= '0;
      i        <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc    <= ACC_W'(bus.t_in);
            i      <= '0;
            busy_q <= 1'b1;
            state  <= ITER;
          end
        end
        ITER: begin
          acc <= sum >> WORD;
          i   <= i + CNT_W'(1);
          if (i == CNT_W'(N_WORDS - 1)) begin
            state <= FINAL;
          end
        end
        FINAL: begin
          // acc < 2P for in-contract inputs, so one conditional subtract suffices.
          if (acc >= ACC_W'(P)) begin
            result_q <= WIDTH'(acc - ACC_W'(P));
          end else begin
            result_q <= acc[WIDTH-1:0];
          end
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_montgomery_reduce.sv
// tb/tb_montgomery_reduce.sv - self-checking bench for montgomery_reduce (small and BLS12-377 configs)
module tb_montgomery_reduce;

  localparam logic [376:0] P_BIG = 377'h1ae3a46_17c510ea_c63b05c0_6ca1493b_1a22d9f3_00f5138f_1ef3622f_ba094800_170b5d44_30000000_8508c000_00000001;
  localparam logic [376:0] A_VAL = 377'h1647170e013bf53a7b050468f43383b17361703bef0431b3f0f3ddad4af519168f4af9b29e96740671f4fbb2b93eb11;
  localparam logic [376:0] B_VAL = 377'h144b5478f0886377ee7fe272cd4ca5a12f1e38816016588cffe3240b0776a00199763223e90b4b30d4f21c3d098f416;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_bad;

  logic [1023:0] p_s, p_b, rinv_s, rinv_b;

  montgomery_reduce_if #(.WIDTH(8))   sif ();
  montgomery_reduce_if #(.WIDTH(377)) bif ();

  montgomery_reduce #(
    .WIDTH(8), .WORD(4), .N_WORDS(2), .P(8'hFB), .P_INV_NEG(4'hD)
  ) u_small (
    .clk   (clk),
    .reset (rst_n),
    .bus   (sif)
  );

  montgomery_reduce #(
    .WIDTH(377), .WORD(64), .N_WORDS(6), .P(P_BIG), .P_INV_NEG(64'h8508bfff_ffffffff)
  ) u_big (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: result is the unique r in [0,p) with r == t * R^-1 (mod p),
  // R^-1 obtained by Fermat inversion (R^(p-2) mod p).
  function automatic logic [1023:0] modpow(input logic [1023:0] b, input logic [1023:0] e,
                                           input logic [1023:0] m);
    logic [1023:0] r;
    logic [1023:0] bb;
    r  = 1;
    bb = b % m;
    for (int k = 1023; k >= 0; k--) begin
      r = (r * r) % m;
      if (e[k]) r = (r * bb) % m;
    end
    return r;
  endfunction

  function automatic logic [1023:0] redc_ref(input logic [1023:0] t, input logic [1023:0] p,
                                             input logic [1023:0] rinv);
    return ((t % p) * rinv) % p;
  endfunction

  function automatic logic get_done(input bit big);
    return big ? bif.done : sif.done;
  endfunction

  function automatic logic get_busy(input bit big);
    return big ? bif.busy : sif.busy;
  endfunction

  function automatic logic [1023:0] get_result(input bit big);
    return big ? 1024'(bif.result) : 1024'(sif.result);
  endfunction

  task automatic drive(input bit big, input logic s, input logic [1023:0] t);
    if (big) begin
      bif.start = s;
      bif.t_in  = t[753:0];
    end else begin
      sif.start = s;
      sif.t_in  = t[15:0];
    end
  endtask

  // Called at a negedge; returns at the negedge where done is high.
  task automatic job(input bit big, input logic [1023:0] t, input logic [1023:0] exp,
                     input bit noise, input string tag);
    int lat;
    int n;
    logic [1023:0] junk;
    n = big ? 6 : 2;
    drive(big, 1'b1, t);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    check({tag, "_busy"}, 1024'(get_busy(big)), 1);
    while (!get_done(big) && lat < 40) begin
      junk = {$urandom, $urandom};
      if (noise) drive(big, 1'($urandom % 2), junk);
      else       drive(big, 1'b0, t);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    drive(big, 1'b0, t);
    check({tag, "_latency"}, 1024'(lat), 1024'(n + 2));
    check({tag, "_result"}, get_result(big), exp);
  endtask

  // No further done and result held while idle.
  task automatic idle(input bit big, input int cycles, input logic [1023:0] exp);
    int dones;
    dones = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (get_done(big)) dones++;
    end
    check("idle_no_done", 1024'(dones), 0);
    check("idle_result_held", get_result(big), exp);
  endtask

  initial begin
    logic [1023:0] t;
    logic [1023:0] e;
    logic [1023:0] mask;
    bit chain;
    bit noise;

    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(0, 1'b0, 0);
    drive(1, 1'b0, 0);

    p_s    = 251;
    p_b    = 1024'(P_BIG);
    rinv_s = modpow(1024'(256), p_s - 2, p_s);
    rinv_b = modpow(1024'(1) << 384, p_b - 2, p_b);
    mask   = (1024'(1) << 754) - 1;

    repeat (3) @(negedge clk);
    check("rst_small_busy",   1024'(sif.busy), 0);
    check("rst_small_done",   1024'(sif.done), 0);
    check("rst_small_result", 1024'(sif.result), 0);
    check("rst_big_busy",     1024'(bif.busy), 0);
    check("rst_big_result",   1024'(bif.result), 0);
    rst_n = 1'b1;
    @(negedge clk);

    job(0, 0, 0, 0, "s_zero");
    idle(0, 2, 0);
    job(0, 1, 8'hC9, 0, "s_one");
    idle(0, 1, 8'hC9);
    job(0, 1280, 5, 0, "s_5r");
    idle(0, 1, 5);
    job(0, 64255, 8'h32, 0, "s_pr_m1");
    check("s_lt_p", 1024'(sif.result < 8'hFB), 1);
    idle(0, 1, 8'h32);

    // Start pulses while busy are ignored; next start lands in the done cycle.
    job(0, 1280, 5, 1, "s_noise");
    job(0, 512, 2, 1, "s_b2b");
    idle(0, 4, 2);

    // Abort mid-iteration.
    drive(0, 1'b1, 1280);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1280);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy",   1024'(sif.busy), 0);
    check("abort_done",   1024'(sif.done), 0);
    check("abort_result", 1024'(sif.result), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(0, 6, 0);
    job(0, 256, 1, 0, "s_after_rst");
    idle(0, 1, 1);

    t = 1024'(A_VAL) * 1024'(B_VAL);
    e = redc_ref(t, p_b, rinv_b);
    job(1, t, e, 0, "b_ab");
    idle(1, 1, e);

    for (int k = 0; k < 1000; k++) begin
      t = '0;
      for (int w = 0; w < 24; w++) t = {t[991:0], 32'($urandom)};
      t = t & mask;
      if (k == 0) t = mask;
      e = redc_ref(t, p_b, rinv_b);
      chain = ($urandom % 3) == 0;
      noise = ($urandom % 4) == 0;
      job(1, t, e, noise, "b_rand");
      if (!chain) idle(1, 1, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
